// File: rtl/imem_port_arbiter.sv
// Single-port instruction-RAM arbiter: fetch stage vs program loader, round-robin on contention,
// byte-to-word address translation with misalignment/range rejection, one-cycle response path.
module imem_port_arbiter #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_req,
  input  logic [31:0]      f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [31:0]      f_rdata,
  output logic             f_err,
  input  logic             l_req,
  input  logic             l_we,
  input  logic [31:0]      l_addr,
  input  logic [31:0]      l_wdata,
  output logic             l_gnt,
  output logic             l_rvalid,
  output logic [31:0]      l_rdata,
  output logic             l_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  // 31-bit compare keeps DEPTH = 2**30 representable.
  localparam logic [30:0] DEPTH_WORDS = 31'(DEPTH);

  owner_e      last_gnt, last_gnt_nxt;
  owner_e      resp_owner, resp_owner_nxt;
  logic        resp_valid, resp_valid_nxt;
  logic        resp_err, resp_err_nxt;
  logic        resp_wr, resp_wr_nxt;

  logic [31:0] sel_addr;
  logic        sel_bad;
  logic        gnt_any;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    f_gnt          = 1'b0;
    l_gnt          = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    last_gnt_nxt   = last_gnt;
    resp_valid_nxt = 1'b0;
    resp_owner_nxt = OWN_FETCH;
    resp_err_nxt   = 1'b0;
    resp_wr_nxt    = 1'b0;

    // Under contention the requester that did not win last time goes first.
    if (rst_n) begin
      if (f_req && (!l_req || last_gnt == OWN_LOADER)) begin
        f_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end

    gnt_any  = f_gnt | l_gnt;
    sel_addr = l_gnt ? l_addr : f_addr;
    sel_bad  = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr[31:2]} >= DEPTH_WORDS);

    if (gnt_any) begin
      mem_en         = !sel_bad;
      mem_we         = !sel_bad && l_gnt && l_we;
      last_gnt_nxt   = l_gnt ? OWN_LOADER : OWN_FETCH;
      resp_valid_nxt = 1'b1;
      resp_owner_nxt = l_gnt ? OWN_LOADER : OWN_FETCH;
      resp_err_nxt   = sel_bad;
      resp_wr_nxt    = l_gnt && l_we;
    end
  end

  assign mem_idx   = sel_addr[IDX_W+1:2];
  assign mem_wdata = l_wdata;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    if (!rst_n) begin
      last_gnt   <= OWN_LOADER;
      resp_valid <= 1'b0;
      resp_owner <= OWN_FETCH;
      resp_err   <= 1'b0;
      resp_wr    <= 1'b0;
    end else begin
      last_gnt   <= last_gnt_nxt;
      resp_valid <= resp_valid_nxt;
      resp_owner <= resp_owner_nxt;
      resp_err   <= resp_err_nxt;
      resp_wr    <= resp_wr_nxt;
    end
  end

  // Read data is forwarded only for a good read; write acks and errors return zero.
  always_comb begin
    f_rvalid = resp_valid && (resp_owner == OWN_FETCH);
    l_rvalid = resp_valid && (resp_owner == OWN_LOADER);
    f_err    = f_rvalid && resp_err;
    l_err    = l_rvalid && resp_err;
    f_rdata  = (f_rvalid && !resp_err && !resp_wr) ? mem_rdata : 32'h0;
    l_rdata  = (l_rvalid && !resp_err && !resp_wr) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model with its own memory image.
module tb_imem_port_arbiter;
  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             f_req = 1'b0;
  logic [31:0]      f_addr = '0;
  logic             f_gnt, f_rvalid, f_err;
  logic [31:0]      f_rdata;
  logic             l_req = 1'b0;
  logic             l_we = 1'b0;
  logic [31:0]      l_addr = '0;
  logic [31:0]      l_wdata = '0;
  logic             l_gnt, l_rvalid, l_err;
  logic [31:0]      l_rdata;
  logic             mem_en, mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 3) return 32'h00A0_0093;
    return 32'hC0DE_0000 ^ (32'(i) * 32'h9E37_79B1);
  endfunction

  // Instruction RAM attached to the DUT; unwritten words read their initial pattern.
  logic [31:0] ram    [DEPTH];
  bit          ram_wr [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_idx]    <= mem_wdata;
        ram_wr[mem_idx] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_idx] ? ram[mem_idx] : init_word(int'(mem_idx));
      end
    end
  end

  // Reference model: who won most recently, its own memory image, and expected responses.
  logic [31:0]      ref_mem [DEPTH];
  bit               ref_last_ldr = 1'b1;
  bit               e_fg, e_lg, e_en, e_we;
  logic [IDX_W-1:0] e_idx;
  bit               n_fv, n_lv, n_fe, n_le;
  logic [31:0]      n_fd, n_ld;
  bit               e_fv, e_lv, e_fe, e_le;
  logic [31:0]      e_fd = '0, e_ld = '0;

  task automatic predict();
    logic [31:0] a;
    bit          bad;
    int          w;
    e_fg = 1'b0;
    e_lg = 1'b0;
    if (rst_n) begin
      if (f_req && l_req) begin
        if (ref_last_ldr) e_fg = 1'b1; else e_lg = 1'b1;
      end else begin
        e_fg = f_req;
        e_lg = l_req;
      end
    end
    a     = e_lg ? l_addr : f_addr;
    bad   = (a % 4 != 0) || (a / 4 >= DEPTH);
    w     = bad ? 0 : int'(a / 4);
    e_idx = IDX_W'(a / 4);
    e_en  = (e_fg || e_lg) && !bad;
    e_we  = e_en && e_lg && l_we;
    n_fv  = e_fg;
    n_lv  = e_lg;
    n_fe  = e_fg && bad;
    n_le  = e_lg && bad;
    n_fd  = (e_fg && !bad) ? ref_mem[w] : 32'h0;
    n_ld  = (e_lg && !bad && !l_we) ? ref_mem[w] : 32'h0;
  endtask

  task automatic drive(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                       input logic [31:0] la, input logic [31:0] ld);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
    #1;
    predict();
  endtask

  task automatic clock();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      ref_last_ldr = 1'b1;
      e_fv = 1'b0; e_lv = 1'b0; e_fe = 1'b0; e_le = 1'b0; e_fd = '0; e_ld = '0;
    end else begin
      if (e_fg) ref_last_ldr = 1'b0;
      else if (e_lg) ref_last_ldr = 1'b1;
      if (e_we) ref_mem[e_idx] = l_wdata;
      e_fv = n_fv; e_lv = n_lv; e_fe = n_fe; e_le = n_le; e_fd = n_fd; e_ld = n_ld;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 32'h0C, 1'b0, 1'b0, '0, '0);
      n_cmp++;
      if ({f_gnt, l_gnt, mem_en} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_gnt: got gnt/en=%b expected 000", {f_gnt, l_gnt, mem_en});
      end
      clock();
      n_cmp++;
      if ({f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata} !== 68'h0) begin
        n_bad++;
        $display("FAIL reset_resp: got %h expected 0",
                 {f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata});
      end
    end
    rst_n = 1'b1;
    drive(1'b1, 32'h0C, 1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (f_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_gnt: got f_gnt=%b expected 1", f_gnt);
    end
    clock();
  endtask

  task automatic test_fetch_read();
    drive(1'b1, 32'h0C, 1'b0, 1'b0, '0, '0);
    n_cmp++;
    if ({f_gnt, mem_en, mem_we, mem_idx} !== {3'b110, 10'd3}) begin
      n_bad++;
      $display("FAIL fetch_req: got gnt/en/we/idx=%b/%b/%b/%0d expected 1/1/0/3",
               f_gnt, mem_en, mem_we, mem_idx);
    end
    clock();
    n_cmp++;
    if ({f_rvalid, f_err, f_rdata, l_rvalid} !== {2'b10, 32'h00A0_0093, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_resp: got rv=%b err=%b data=%h l_rv=%b expected 1 0 00a00093 0",
               f_rvalid, f_err, f_rdata, l_rvalid);
    end
  endtask

  task automatic test_loader_write_fetch();
    drive(1'b0, '0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    n_cmp++;
    if ({l_gnt, mem_en, mem_we, mem_idx, mem_wdata} !== {3'b111, 10'd4, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL ldr_write_req: got gnt/en/we/idx/wd=%b/%b/%b/%0d/%h expected 1/1/1/4/deadbeef",
               l_gnt, mem_en, mem_we, mem_idx, mem_wdata);
    end
    clock();
    n_cmp++;
    if ({l_rvalid, l_err, l_rdata, f_rvalid} !== {2'b10, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL ldr_write_ack: got rv=%b err=%b data=%h f_rv=%b expected 1 0 0 0",
               l_rvalid, l_err, l_rdata, f_rvalid);
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
    clock();
    n_cmp++;
    if ({f_rvalid, f_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL fetch_after_write: got rv=%b data=%h expected 1 deadbeef", f_rvalid, f_rdata);
    end
  endtask

  task automatic test_contention();
    bit fetch_turn;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    clock();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      fetch_turn = (c % 2 == 0);
      drive(1'b1, 32'h0C, 1'b1, 1'b0, 32'h10, '0);
      n_cmp++;
      if ({f_gnt, l_gnt} !== {fetch_turn, !fetch_turn}) begin
        n_bad++;
        $display("FAIL contention_gnt[%0d]: got f/l=%b%b expected %b%b",
                 c, f_gnt, l_gnt, fetch_turn, !fetch_turn);
      end
      clock();
      n_cmp++;
      if ({f_rvalid, f_rdata, l_rvalid, l_rdata} !==
          {fetch_turn, fetch_turn ? 32'h00A0_0093 : 32'h0,
           !fetch_turn, fetch_turn ? 32'h0 : 32'hDEAD_BEEF}) begin
        n_bad++;
        $display("FAIL contention_resp[%0d]: got f=%b/%h l=%b/%h", c, f_rvalid, f_rdata,
                 l_rvalid, l_rdata);
      end
    end
  endtask

  task automatic test_errors();
    drive(1'b1, 32'h02, 1'b0, 1'b0, '0, '0);
    n_cmp++;
    if ({f_gnt, mem_en} !== 2'b10) begin
      n_bad++;
      $display("FAIL misaligned_req: got gnt/en=%b%b expected 10", f_gnt, mem_en);
    end
    clock();
    n_cmp++;
    if ({f_rvalid, f_err, f_rdata} !== {2'b11, 32'h0}) begin
      n_bad++;
      $display("FAIL misaligned_resp: got rv=%b err=%b data=%h expected 1 1 0",
               f_rvalid, f_err, f_rdata);
    end
    drive(1'b0, '0, 1'b1, 1'b1, 32'(DEPTH * 4), 32'h1234_5678);
    n_cmp++;
    if ({l_gnt, mem_en, mem_we} !== 3'b100) begin
      n_bad++;
      $display("FAIL range_req: got gnt/en/we=%b%b%b expected 100", l_gnt, mem_en, mem_we);
    end
    clock();
    n_cmp++;
    if ({l_rvalid, l_err, l_rdata} !== {2'b11, 32'h0}) begin
      n_bad++;
      $display("FAIL range_resp: got rv=%b err=%b data=%h expected 1 1 0", l_rvalid, l_err, l_rdata);
    end
    drive(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
    clock();
    n_cmp++;
    if ({ram_wr[0], f_rdata} !== {1'b0, init_word(0)}) begin
      n_bad++;
      $display("FAIL range_no_write: got written=%b word0=%h expected 0 %h",
               ram_wr[0], f_rdata, init_word(0));
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 32'h0C, 1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (f_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL midop_gnt: got %b expected 1", f_gnt);
    end
    clock();
    rst_n = 1'b0;
    drive(1'b1, 32'h0C, 1'b0, 1'b0, '0, '0);
    n_cmp++;
    if ({f_gnt, mem_en} !== 2'b00) begin
      n_bad++;
      $display("FAIL midop_gnt_in_reset: got gnt/en=%b%b expected 00", f_gnt, mem_en);
    end
    clock();
    n_cmp++;
    if ({f_rvalid, f_rdata} !== 33'h0) begin
      n_bad++;
      $display("FAIL midop_dropped: got rv=%b data=%h expected 0 0", f_rvalid, f_rdata);
    end
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    clock();
    n_cmp++;
    if ({f_rvalid, l_rvalid} !== 2'b00) begin
      n_bad++;
      $display("FAIL midop_after_release: got f/l rv=%b%b expected 00", f_rvalid, l_rvalid);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      2:       return 32'((DEPTH - 1) * 4);
      3:       return 32'(DEPTH * 4);
      default: return 32'($urandom_range(0, 63) * 4);
    endcase
  endfunction

  task automatic test_random();
    bit          fr = 1'b0, lr = 1'b0, lw = 1'b0, fh = 1'b0, lh = 1'b0;
    logic [31:0] fa = '0, la = '0, ld = '0;
    int          fwait = 0, lwait = 0;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      if (!fh) begin
        fr = ($urandom_range(0, 2) != 0);
        fa = rand_addr();
      end
      if (!lh) begin
        lr = ($urandom_range(0, 2) != 0);
        lw = $urandom_range(0, 1) == 1;
        la = rand_addr();
        ld = $urandom;
      end
      drive(fr, fa, lr, lw, la, ld);
      n_cmp++;
      if ({f_gnt, l_gnt, mem_en, mem_we} !== {e_fg, e_lg, e_en, e_we}) begin
        n_bad++;
        $display("FAIL rand_gnt[%0d]: got f/l/en/we=%b%b%b%b expected %b%b%b%b", c,
                 f_gnt, l_gnt, mem_en, mem_we, e_fg, e_lg, e_en, e_we);
      end
      if (e_en) begin
        n_cmp++;
        if (mem_idx !== e_idx) begin
          n_bad++;
          $display("FAIL rand_idx[%0d]: got %0d expected %0d", c, mem_idx, e_idx);
        end
      end
      fwait = (rst_n && fr && !f_gnt) ? fwait + 1 : 0;
      lwait = (rst_n && lr && !l_gnt) ? lwait + 1 : 0;
      n_cmp++;
      if (fwait > 1 || lwait > 1) begin
        n_bad++;
        $display("FAIL rand_wait[%0d]: got waits f=%0d l=%0d expected at most 1", c, fwait, lwait);
      end
      fh = fr && !f_gnt;
      lh = lr && !l_gnt;
      clock();
      n_cmp++;
      if ({f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata} !==
          {e_fv, e_fe, e_fd, e_lv, e_le, e_ld}) begin
        n_bad++;
        $display("FAIL rand_resp[%0d]: got f=%b%b/%h l=%b%b/%h expected f=%b%b/%h l=%b%b/%h", c,
                 f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata,
                 e_fv, e_fe, e_fd, e_lv, e_le, e_ld);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_fetch_read();
    test_loader_write_fetch();
    test_contention();
    test_errors();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
